// File: rtl/dmux4way16_stream.sv
// -----------------------------------------------------------------------------
// dmux4way16_stream
//
// Streaming 1-to-4 demultiplexer. It takes one stream of WIDTH-bit words and
// routes each word to output channel a, b, c or d, chosen by in_sel. Each
// channel has its own DEPTH-entry FIFO, so a stalled sink on one channel
// never blocks traffic to the other three.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst_n      synchronous, active-low reset
//   in_data    word to route
//   in_sel     destination channel: 0=a, 1=b, 2=c, 3=d
//   in_valid   in_data / in_sel are valid
//   in_ready   the channel currently selected by in_sel has a free entry
//   a,b,c,d    head-of-FIFO word of channels 0..3 (0 while that channel is empty)
//   out_valid  bit i: channel i head word is valid
//   out_ready  bit i: consumer i accepts the head word
//   busy       at least one channel FIFO holds data
//
// Parameters
//   WIDTH      data width
//   DEPTH      entries per channel FIFO (power of two, >= 2)
// -----------------------------------------------------------------------------
module dmux4way16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy
);

    localparam int NCH   = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-channel FIFO state. Pointers are exactly log2(DEPTH) bits, so they
    // wrap modulo DEPTH by plain overflow.
    logic [PTR_W-1:0] wptr  [NCH];
    logic [PTR_W-1:0] rptr  [NCH];
    logic [CNT_W-1:0] count [NCH];
    logic [WIDTH-1:0] mem   [NCH][DEPTH];

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   push_vec;
    logic [NCH-1:0]   pop_vec;
    logic [WIDTH-1:0] head  [NCH];

    // ------------------------------------------------------------------
    // Status flags, derived only from registered counts.
    // ------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            full[ch]  = (count[ch] == CNT_W'(DEPTH));
            empty[ch] = (count[ch] == '0);
        end
    end

    // A full channel refuses a push even when it pops in the same cycle;
    // this keeps out_ready out of the in_ready path.
    assign in_ready  = ~full[in_sel];
    assign out_valid = ~empty;
    assign busy      = |out_valid;

    // ------------------------------------------------------------------
    // Per-channel push/pop strobes.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned and no latch
        // is inferred.
        push_vec = '0;
        if (in_valid && in_ready) begin
            push_vec[in_sel] = 1'b1;
        end
        pop_vec = out_valid & out_ready;
    end

    // ------------------------------------------------------------------
    // Pointers and counts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                // NOTE: sequential state is updated with non-blocking
                // assignments only, so every register samples pre-edge values
                // regardless of statement order.
                wptr[ch]  <= '0;
                rptr[ch]  <= '0;
                count[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (push_vec[ch]) begin
                    wptr[ch] <= wptr[ch] + PTR_W'(1);
                end
                if (pop_vec[ch]) begin
                    rptr[ch] <= rptr[ch] + PTR_W'(1);
                end
                // Push and pop together leave the count unchanged.
                count[ch] <= count[ch] + CNT_W'(push_vec[ch]) - CNT_W'(pop_vec[ch]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage.
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset. Its contents are only ever observed
    // through a non-zero count, and the counts are reset, so clearing the array
    // would add reset fan-out with no visible effect.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            // Gating with rst_n ensures a word presented during reset is dropped.
            if (rst_n && push_vec[ch]) begin
                mem[ch][wptr[ch]] <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head-of-FIFO outputs. An empty channel drives 0, never stale data.
    // ------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            head[ch] = '0;
            if (!empty[ch]) begin
                head[ch] = mem[ch][rptr[ch]];
            end
        end
    end

    assign a = head[0];
    assign b = head[1];
    assign c = head[2];
    assign d = head[3];

endmodule

// File: tb/tb_dmux4way16_stream.sv
// -----------------------------------------------------------------------------
// Testbench for dmux4way16_stream. A reference model keeps one queue per
// channel. Every cycle the DUT outputs are compared with the model on the
// falling edge. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_dmux4way16_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    dmux4way16_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] obs [4];
    assign obs[0] = a;
    assign obs[1] = b;
    assign obs[2] = c;
    assign obs[3] = d;

    // Reference model: one word queue per channel.
    logic [WIDTH-1:0] mq [4][$];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Compares every output against the model; call while away from the edge.
    task automatic check_outputs();
        int nonempty;
        nonempty = 0;
        check("in_ready", 32'(in_ready), 32'(mq[in_sel].size() < DEPTH));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
            check($sformatf("data%0d", i), 32'(obs[i]),
                  (mq[i].size() > 0) ? 32'(mq[i][0]) : 32'd0);
            if (mq[i].size() > 0) nonempty++;
        end
        check("busy", 32'(busy), 32'(nonempty > 0));
    endtask

    // One clock cycle. Called just after a rising edge: drive the inputs,
    // check on the falling edge, then advance the model across the next edge.
    task automatic cycle(input logic v, input logic [1:0] s,
                         input logic [WIDTH-1:0] dat, input logic [3:0] r);
        bit       acc;
        bit [3:0] pop;
        in_valid  = v;
        in_sel    = s;
        in_data   = dat;
        out_ready = r;
        @(negedge clk);
        check_outputs();
        acc = v && (mq[s].size() < DEPTH);
        for (int i = 0; i < 4; i++) pop[i] = r[i] && (mq[i].size() > 0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (pop[i]) void'(mq[i].pop_front());
        if (acc) mq[s].push_back(dat);
        #1;
    endtask

    // Holds reset for one edge while offering a word, which must be dropped.
    task automatic do_reset(input logic [WIDTH-1:0] dat);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'b00;
        in_data   = dat;
        out_ready = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mq[i].delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH + 2; k++) cycle(1'b0, 2'b00, '0, 4'b1111);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        out_ready = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // One word to each channel on consecutive cycles, all sinks ready.
        cycle(1'b1, 2'b00, 16'h1111, 4'b1111);
        cycle(1'b1, 2'b01, 16'h2222, 4'b1111);
        cycle(1'b1, 2'b10, 16'h3333, 4'b1111);
        cycle(1'b1, 2'b11, 16'h4444, 4'b1111);
        cycle(1'b0, 2'b00, 16'h0000, 4'b1111);
        cycle(1'b0, 2'b00, 16'h0000, 4'b1111);
        check("busy_idle", 32'(busy), 32'd0);

        // Stall channel c and fill it; the third word waits.
        cycle(1'b1, 2'b10, 16'hAAAA, 4'b1011);
        cycle(1'b1, 2'b10, 16'hBBBB, 4'b1011);
        cycle(1'b1, 2'b10, 16'hCCCC, 4'b1011);
        check("c_held", 32'(c), 32'hAAAA);
        // Channel c full: switch to a with in_valid held high.
        cycle(1'b1, 2'b00, 16'h5555, 4'b1011);
        cycle(1'b0, 2'b00, 16'h0000, 4'b1011);
        check("c_after_switch", 32'(c), 32'hAAAA);
        // Release c, then deliver the stalled word.
        cycle(1'b1, 2'b10, 16'hCCCC, 4'b1111);
        cycle(1'b0, 2'b10, 16'h0000, 4'b1111);
        drain();

        // Channel b full, pop and push offered in the same cycle.
        cycle(1'b1, 2'b01, 16'h0B01, 4'b0000);
        cycle(1'b1, 2'b01, 16'h0B02, 4'b0000);
        cycle(1'b1, 2'b01, 16'h0B03, 4'b0010);
        check("b_after_pop", 32'(b), 32'h0B02);
        cycle(1'b1, 2'b01, 16'h0B03, 4'b0000);
        drain();

        // out_ready on empty FIFOs has no effect.
        cycle(1'b0, 2'b00, 16'h0000, 4'b1111);
        cycle(1'b0, 2'b11, 16'h0000, 4'b1111);

        // Fill a and d, then reset mid-operation.
        cycle(1'b1, 2'b00, 16'hA001, 4'b0000);
        cycle(1'b1, 2'b11, 16'hD001, 4'b0000);
        cycle(1'b1, 2'b00, 16'hA002, 4'b0000);
        cycle(1'b1, 2'b11, 16'hD002, 4'b0000);
        do_reset(16'h9999);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_a", 32'(a), 32'd0);
        check("mid_rst_d", 32'(d), 32'd0);
        @(posedge clk);
        #1;
        cycle(1'b0, 2'b00, 16'h0000, 4'b1111);

        // Randomized traffic, with sinks often stalled so FIFOs fill.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(WIDTH'($urandom));
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), WIDTH'($urandom),
                      4'($urandom) & 4'($urandom | 32'($urandom_range(0, 1) * 15)));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
